spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_slave_sync.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave (mode 0 style, LSB first) sampled entirely in the clk domain.
// A frame is 8 bits master->slave followed by 8 bits slave->master while
// cs is low. The response byte is either a byte loaded by local logic or,
// if nothing was loaded since the previous frame, the byte just received.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] shadow;
    logic [7:0] tx_buf;
    logic       load_seen;

    // The synchronizers reset to "cs high" so a cs held low across reset
    // cannot open a frame: the block must first observe the real cs high.
    logic [1:0] prime_cnt;
    logic       armed;

    logic       sclk_cur;
    logic       cs_cur;
    logic       mosi_cur;
    logic       sclk_fall;
    logic       csn_rise;
    logic       prime_done;
    logic [7:0] rx_byte_next;
    logic [7:0] tx_pick;
    logic [2:0] bit_cnt_inc;

    assign sclk_cur     = sclk_sync[SYNC_STAGES-1];
    assign cs_cur       = cs_sync[SYNC_STAGES-1];
    assign mosi_cur     = mosi_sync[SYNC_STAGES-1];
    assign sclk_fall    = sclk_prev & ~sclk_cur;
    assign csn_rise     = ~cs_prev & cs_cur;
    assign prime_done   = (prime_cnt == 2'd3);
    assign rx_byte_next = {mosi_cur, shift[7:1]};
    assign bit_cnt_inc  = bit_cnt + 3'd1;

    // Response byte choice at the RX->TX hand-over; a load in that very
    // cycle wins over the buffered byte and over loopback.
    always_comb begin
        tx_pick = rx_byte_next;
        if (tx_load) begin
            tx_pick = tx_data;
        end else if (load_seen) begin
            tx_pick = tx_buf;
        end else begin
            tx_pick = rx_byte_next;
        end
    end

    // Input synchronizers and the one-cycle history used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            if (SYNC_STAGES > 1) begin
                sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
                cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
                mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            end else begin
                sclk_sync <= sclk;
                cs_sync   <= cs;
                mosi_sync <= mosi;
            end
            sclk_prev <= sclk_cur;
            cs_prev   <= cs_cur;
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            shadow    <= 8'h00;
            tx_buf    <= 8'h00;
            load_seen <= 1'b0;
            prime_cnt <= 2'd0;
            armed     <= 1'b0;
            miso      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (!prime_done) begin
                prime_cnt <= prime_cnt + 2'd1;
            end

            if (prime_done && cs_cur) begin
                armed <= 1'b1;
            end

            // A load outside the hand-over cycle is buffered for the next frame.
            if (tx_load) begin
                tx_buf    <= tx_data;
                load_seen <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (!cs_cur && armed) begin
                        state   <= RX;
                        bit_cnt <= 3'd0;
                        shift   <= 8'h00;
                        busy    <= 1'b1;
                    end
                end

                RX: begin
                    if (csn_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        miso      <= 1'b0;
                        bit_cnt   <= 3'd0;
                        shift     <= 8'h00;
                    end else if (sclk_fall) begin
                        shift <= rx_byte_next;
                        if (bit_cnt == 3'd7) begin
                            rx_data   <= rx_byte_next;
                            rx_valid  <= 1'b1;
                            shadow    <= tx_pick;
                            miso      <= tx_pick[0];
                            load_seen <= 1'b0;
                            bit_cnt   <= 3'd0;
                            state     <= TX;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                end

                TX: begin
                    if (csn_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        miso      <= 1'b0;
                        bit_cnt   <= 3'd0;
                    end else if (sclk_fall) begin
                        if (bit_cnt == 3'd7) begin
                            state   <= DONE;
                            miso    <= 1'b0;
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                            miso    <= shadow[bit_cnt_inc];
                        end
                    end
                end

                DONE: begin
                    miso <= 1'b0;
                    if (csn_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    miso    <= 1'b0;
                    bit_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomized scoreboard bench for spi_slave_sync. A frame-level model
// (pending loaded byte or loopback) pushes expected rx bytes and miso
// responses into queues; independent monitors pop and compare.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    // Frame-level reference state
    logic [7:0] m_loaded  = 8'h00;
    logic       m_pending = 1'b0;
    logic [7:0] m_last_rx = 8'h00;

    int rxv_cnt  = 0;
    int ferr_cnt = 0;
    logic ferr_prev = 1'b0;

    int mbit = 0;
    logic [7:0] mbyte = 8'h00;

    spi_slave_sync #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Received-byte and error-pulse monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rxv_cnt++;
                chk("no_ferr_with_rx_valid", {31'd0, frame_err}, 32'd0);
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got rx_valid with data=%0h expected none", rx_data);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                chk("frame_err_width", {31'd0, ferr_prev}, 32'd0);
            end
            ferr_prev = frame_err;
        end else begin
            ferr_prev = 1'b0;
        end
    end

    // miso monitor: the master samples on sclk rises; bits 8..15 are the reply
    always @(posedge sclk or posedge cs) begin
        if (cs) begin
            mbit = 0;
        end else begin
            if (mbit >= 8 && mbit < 16) mbyte[mbit-8] = miso;
            mbit++;
            if (mbit == 16) begin
                if (miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got byte %0h expected none", mbyte);
                end else begin
                    chk("miso_byte", {24'd0, mbyte}, {24'd0, miso_q.pop_front()});
                end
            end
        end
    end

    task automatic do_load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        m_loaded  = d;
        m_pending = 1'b1;
    endtask

    // Run nbits sclk periods of a frame (clk/8); cs is left low.
    task automatic frame(input logic [7:0] mb, input int nbits, input int load_bit,
                         input logic [7:0] load_val);
        logic [7:0] resp;
        cs = 1'b0;
        wait_clk(4);
        for (int b = 0; b < nbits; b++) begin
            wait_clk(2);
            mosi = (b < 8) ? mb[b] : 1'($urandom_range(0, 1));
            wait_clk(2);
            sclk = 1'b1;
            if (b == load_bit) begin
                do_load(load_val);
                wait_clk(3);
            end else begin
                wait_clk(4);
            end
            sclk = 1'b0;
            if (b == 7) begin
                resp      = m_pending ? m_loaded : mb;
                m_pending = 1'b0;
                m_last_rx = mb;
                rx_q.push_back(mb);
                if (nbits == 16) miso_q.push_back(resp);
            end
        end
        wait_clk(4);
    endtask

    task automatic frame_end(input int gap);
        cs = 1'b1;
        wait_clk(gap);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int rv0;
        int kind;
        int nb;
        logic [7:0] mb;

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        wait_clk(3);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(6);

        // Loopback
        rv0 = rxv_cnt;
        frame(8'hA5, 16, -1, 8'h00);
        frame_end(10);
        chk("loopback_rxv_count", rxv_cnt - rv0, 32'd1);
        chk("loopback_busy", {31'd0, busy}, 32'd0);

        // Loaded response
        do_load(8'h3C);
        wait_clk(3);
        frame(8'h81, 16, -1, 8'h00);
        frame_end(10);

        // Late load during TX applies to the following frame
        do_load(8'h3C);
        frame(8'h77, 16, 11, 8'h55);
        frame_end(10);
        frame(8'h99, 16, -1, 8'h00);
        frame_end(10);

        // Abort after 5 RX bits
        fe0 = ferr_cnt; rv0 = rxv_cnt;
        frame(8'hC3, 5, -1, 8'h00);
        frame_end(10);
        chk("abort_ferr_count", ferr_cnt - fe0, 32'd1);
        chk("abort_no_rxv", rxv_cnt - rv0, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rx_data_held", {24'd0, rx_data}, {24'd0, m_last_rx});

        // Reset during TX
        frame(8'hFF, 12, -1, 8'h00);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_miso", {31'd0, miso}, 32'd0);
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        m_loaded = 8'h00; m_pending = 1'b0; m_last_rx = 8'h00;
        wait_clk(3);
        rst = 1'b0;
        // cs still low after reset: no frame may start
        wait_clk(20);
        chk("no_reentry_after_rst", {31'd0, busy}, 32'd0);
        frame_end(10);
        frame(8'h0F, 16, -1, 8'h00);
        frame_end(10);

        // Back-to-back frames, 8 clk of cs high between
        rv0 = rxv_cnt;
        frame(8'h12, 16, -1, 8'h00);
        frame_end(8);
        frame(8'h34, 16, -1, 8'h00);
        frame_end(10);
        chk("b2b_rxv_count", rxv_cnt - rv0, 32'd2);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            mb   = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 4);
            fe0  = ferr_cnt;
            case (kind)
                1: begin do_load(8'($urandom_range(0, 255))); wait_clk(2); frame(mb, 16, -1, 8'h00); end
                2: frame(mb, 16, 3, 8'($urandom_range(0, 255)));
                3: frame(mb, 16, 11, 8'($urandom_range(0, 255)));
                4: begin
                    nb = $urandom_range(1, 7);
                    frame(mb, nb, 2, 8'($urandom_range(0, 255)));
                end
                default: frame(mb, 16, -1, 8'h00);
            endcase
            frame_end($urandom_range(8, 20));
            chk("rand_ferr_delta", ferr_cnt - fe0, (kind == 4) ? 32'd1 : 32'd0);
            chk("rand_busy_idle", {31'd0, busy}, 32'd0);
        end

        wait_clk(20);
        chk("rx_q_drained", rx_q.size(), 32'd0);
        chk("miso_q_drained", miso_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
